seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter CLK_DIV, default 50000, is the clock cycles per digit slot; legal values are CLK_DIV >= 2.
REQ-002 Parameter ACTIVE_LOW, default 1; when 1, seg and an are active-low, and when 0 they are active-high.
REQ-003 Parameter BLANK_LZ, default 1; when 1, a tens digit of 0 is blanked.
REQ-004 Port clk, input, 1 bit: single system clock, rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port en, input, 1 bit: display enable.
REQ-007 Port units, input, 4 bits: BCD units digit from the two-digit counter.
REQ-008 Port tens, input, 4 bits: BCD tens digit from the two-digit counter.
REQ-009 Port seg, output, 7 bits: segments, with seg[0]=a through seg[6]=g.
REQ-010 Port an, output, 2 bits: digit select, with an[0]=units and an[1]=tens.
REQ-011 Port frame_pulse, output, 1 bit: one-cycle strobe at the end of each full scan.

Function
REQ-012 The prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; tick = (prescaler == CLK_DIV-1) while not in IDLE.
REQ-013 The FSM SHALL have the states IDLE, DIG_U and DIG_T.
REQ-014 FSM transitions SHALL be:
  - IDLE->DIG_U when en=1;
  - DIG_U->DIG_T on tick;
  - DIG_T->DIG_U on tick;
  - any state->IDLE when en=0, with priority over tick.
REQ-015 The prescaler SHALL clear to 0 in IDLE and on every state change.
REQ-016 Shadow registers SHALL capture units/tens on every edge entering DIG_U (from IDLE or from DIG_T), so both digits of a frame come from one sample.
REQ-017 Inputs SHALL NOT be sampled at any other time; a mid-frame input change first appears in the next frame.
REQ-018 seg, an and frame_pulse SHALL be registered and computed from the current state, prescaler and shadow values, giving one clock of latency.
REQ-019 Dead time: an SHALL be all-inactive for the cycle in which prescaler==0, so each digit is lit for exactly CLK_DIV-1 clocks per slot.
REQ-020 In DIG_U, only an[0] SHALL be active, and seg SHALL be decode(shadow_units).
REQ-021 In DIG_T, only an[1] SHALL be active, and seg SHALL be decode(shadow_tens), unless BLANK_LZ=1 and shadow_tens==0, in which case an is all-inactive and seg is all-off.
REQ-022 The decode of codes 0-9 SHALL use the standard 7-segment patterns; 1 = b,c and 7 = a,b,c.
REQ-023 The decode of codes 10-15 SHALL be a dash (g only).
REQ-024 In IDLE, seg and an SHALL be all-inactive, and frame_pulse SHALL be 0.
REQ-025 frame_pulse SHALL be high for exactly one clock, asserted the cycle after the DIG_T->DIG_U edge.
REQ-026 frame_pulse SHALL NOT assert when DIG_T is exited to IDLE.
REQ-027 When en falls mid-slot, the state SHALL be IDLE on the next edge and the outputs all-inactive one clock later; the partial frame is discarded without a frame_pulse.
REQ-028 Simultaneous en=0 and tick SHALL go to IDLE.
REQ-029 When en rises, scanning SHALL restart at DIG_U with a fresh sample.

Reset
REQ-030 While rst_n=0, the block SHALL immediately, without waiting for a clock edge, force:
  - state=IDLE;
  - prescaler=0;
  - shadows=0;
  - seg and an all-inactive (polarity per ACTIVE_LOW);
  - frame_pulse=0.
REQ-031 After rst_n deasserts, the first transition SHALL require en=1 sampled on a rising clk edge.

Structure
REQ-032 Package seg7_pkg SHALL hold the state enum (IDLE, DIG_U, DIG_T), the 7-bit active-high segment pattern constants for 0-9, and the DASH pattern.
REQ-033 Sub-module bcd_to_seg7 SHALL be a combinational 4-bit to 7-bit active-high decoder, instantiated once and fed by a mux of the shadows.
REQ-034 Polarity inversion SHALL be applied at the output registers only.
REQ-035 The prescaler width SHALL be $clog2(CLK_DIV).

Verification (CLK_DIV=4, ACTIVE_LOW=1, BLANK_LZ=1 unless stated)
REQ-036 Reset/idle: assert rst_n=0 mid-scan -> seg=7'h7F, an=2'b11 and frame_pulse=0 without a clock edge; hold en=0 -> outputs stay inactive.
REQ-037 Basic scan: units=3, tens=5, en=1 -> pattern repeats every 8 clocks:
  - an = 11, 10, 10, 10, 11, 01, 01, 01;
  - seg = ~decode(3) during an=10 and ~decode(5) during an=01;
  - frame_pulse high once per 8 clocks.
REQ-038 Leading zero: units=7, tens=0 -> an never equals 01.
REQ-039 Leading zero disabled: units=7, tens=0, BLANK_LZ=0 -> the tens slot shows ~decode(0).
REQ-040 Invalid code and snapshot: tens=4'hC -> tens slot seg = ~DASH (7'b0111111).
REQ-041 Snapshot: changing units during DIG_T -> the new value appears only after the next frame_pulse.
REQ-042 Enable drop: en=0 on the clock where tick occurs in DIG_T -> no frame_pulse, outputs inactive one clock later; when en returns to 1, the first lit digit is units after one dead-time cycle.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and active-high segment patterns for the two-digit scan driver.
// Bit order is seg[0]=a .. seg[6]=g.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIG_U = 2'd1,
    DIG_T = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-high 7-segment decoder; non-BCD codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver: time-slices units/tens with a dead-time
// cycle per slot and strobes frame_pulse once per completed units+tens scan.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 50000,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LZ   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] units,
  input  logic [3:0] tens,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_pulse
);

  localparam int unsigned   PW      = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PMAX    = PW'(CLK_DIV - 1);
  localparam logic [6:0]    SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]    AN_OFF  = ACTIVE_LOW ? 2'b11 : 2'b00;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [3:0]      sh_units_q, sh_tens_q;
  logic            tick, capture, blank_t;
  logic [3:0]      dec_sel;
  logic [6:0]      dec_seg;
  logic [6:0]      seg_act;
  logic [1:0]      an_act;
  logic            frame_d;
  logic [6:0]      seg_q;
  logic [1:0]      an_q;
  logic            frame_q;

  always_comb begin
    tick = (state_q != IDLE) && (presc_q == PMAX);

    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = DIG_U;
        DIG_U:   if (tick) state_d = DIG_T;
        DIG_T:   if (tick) state_d = DIG_U;
        default: state_d = IDLE;
      endcase
    end

    // Every slot starts at prescaler 0 so the dead-time cycle lines up with it.
    if ((state_q == IDLE) || (state_d != state_q) || (presc_q == PMAX))
      presc_d = '0;
    else
      presc_d = presc_q + 1'b1;

    capture = (state_d == DIG_U) && (state_q != DIG_U);
    frame_d = (state_q == DIG_T) && (state_d == DIG_U);
  end

  assign dec_sel = (state_q == DIG_T) ? sh_tens_q : sh_units_q;

  bcd_to_seg7 u_dec (
    .bcd_i (dec_sel),
    .seg_o (dec_seg)
  );

  always_comb begin
    blank_t = BLANK_LZ && (sh_tens_q == 4'd0);
    seg_act = 7'h00;
    an_act  = 2'b00;
    case (state_q)
      DIG_U: begin
        seg_act = dec_seg;
        an_act  = (presc_q == '0) ? 2'b00 : 2'b01;
      end
      DIG_T: begin
        if (!blank_t) begin
          seg_act = dec_seg;
          an_act  = (presc_q == '0) ? 2'b00 : 2'b10;
        end
      end
      default: begin
        seg_act = 7'h00;
        an_act  = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      sh_units_q <= 4'd0;
      sh_tens_q  <= 4'd0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
      frame_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      if (capture) begin
        sh_units_q <= units;
        sh_tens_q  <= tens;
      end
      // Polarity is applied only here; everything upstream is active-high.
      seg_q   <= ACTIVE_LOW ? ~seg_act : seg_act;
      an_q    <= ACTIVE_LOW ? ~an_act  : an_act;
      frame_q <= frame_d;
    end
  end

  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_pulse = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: CLK_DIV=4 active-low with blanking, plus an active-high
// non-blanking instance driven by the same stimulus.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] units, tens;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       fp_a, fp_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.CLK_DIV(4), .ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .units(units), .tens(tens),
    .seg(seg_a), .an(an_a), .frame_pulse(fp_a)
  );

  seg7_scan_driver #(.CLK_DIV(4), .ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .units(units), .tens(tens),
    .seg(seg_b), .an(an_b), .frame_pulse(fp_b)
  );

  function automatic logic [6:0] dec(input logic [3:0] c);
    case (c)
      4'd0: dec = 7'b0111111;
      4'd1: dec = 7'b0000110;
      4'd2: dec = 7'b1011011;
      4'd3: dec = 7'b1001111;
      4'd4: dec = 7'b1100110;
      4'd5: dec = 7'b1101101;
      4'd6: dec = 7'b1111101;
      4'd7: dec = 7'b0000111;
      4'd8: dec = 7'b1111111;
      4'd9: dec = 7'b1101111;
      default: dec = 7'b1000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_seg"}, {1'b0, seg_a}, 8'h7F);
    chk({tag, "_an"},  {6'd0, an_a},  8'h03);
    chk({tag, "_fp"},  {7'd0, fp_a},  8'h00);
    chk({tag, "_seg_hi"}, {1'b0, seg_b}, 8'h00);
    chk({tag, "_an_hi"},  {6'd0, an_b},  8'h00);
    chk({tag, "_fp_hi"},  {7'd0, fp_b},  8'h00);
  endtask

  // Phase p of the 8-cycle frame: 0 and 4 are dead-time cycles, 7 carries frame_pulse.
  task automatic chk_phase(input int p, input logic [3:0] u, input logic [3:0] t);
    logic       dead, tslot, blank;
    logic [3:0] sel;
    logic [1:0] an1, an2;
    logic [6:0] seg1;
    dead  = (p == 0) || (p == 4);
    tslot = (p >= 4);
    blank = tslot && (t == 4'd0);
    sel   = tslot ? t : u;
    an1   = (dead || blank) ? 2'b11 : (tslot ? 2'b01 : 2'b10);
    seg1  = blank ? 7'h7F : ~dec(sel);
    an2   = dead ? 2'b00 : (tslot ? 2'b10 : 2'b01);
    chk($sformatf("ph%0d_seg", p),    {1'b0, seg_a}, {1'b0, seg1});
    chk($sformatf("ph%0d_an", p),     {6'd0, an_a},  {6'd0, an1});
    chk($sformatf("ph%0d_fp", p),     {7'd0, fp_a},  {7'd0, (p == 7)});
    chk($sformatf("ph%0d_seg_hi", p), {1'b0, seg_b}, {1'b0, dec(sel)});
    chk($sformatf("ph%0d_an_hi", p),  {6'd0, an_b},  {6'd0, an2});
    chk($sformatf("ph%0d_fp_hi", p),  {7'd0, fp_b},  {7'd0, (p == 7)});
  endtask

  task automatic phases(input int from, input int to, input logic [3:0] u, input logic [3:0] t);
    for (int p = from; p <= to; p++) begin
      step();
      chk_phase(p, u, t);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; units = 4'd3; tens = 4'd5;
    repeat (3) step();
    chk_idle("reset");

    rst_n = 1'b1;
    repeat (3) step();
    chk_idle("idle_en0");

    // Basic scan 3/5
    en = 1'b1;
    step();
    chk_idle("first_edge");
    phases(0, 7, 3, 5);
    phases(0, 7, 3, 5);

    // Units change while tens is shown: old frame finishes unchanged
    phases(0, 4, 3, 5);
    units = 4'd9;
    phases(5, 7, 3, 5);
    phases(0, 7, 9, 5);

    // Leading zero; inputs changed right after the strobe land one frame later
    units = 4'd7; tens = 4'd0;
    phases(0, 7, 9, 5);
    phases(0, 7, 7, 0);
    phases(0, 7, 7, 0);

    // Non-BCD tens shows a dash
    tens = 4'hC;
    phases(0, 7, 7, 0);
    phases(0, 7, 7, 4'hC);

    // Enable drops on the DIG_T tick edge
    phases(0, 6, 7, 4'hC);
    en = 1'b0;
    step();
    chk("drop_an",    {6'd0, an_a},  8'h01);
    chk("drop_fp",    {7'd0, fp_a},  8'h00);
    chk("drop_fp_hi", {7'd0, fp_b},  8'h00);
    step();
    chk_idle("drop_idle");
    step();
    chk_idle("drop_idle2");
    units = 4'd2; tens = 4'd8;
    en = 1'b1;
    step();
    chk_idle("reen_edge");
    phases(0, 7, 2, 8);

    // Asynchronous reset between clock edges, right on a frame_pulse cycle
    phases(0, 6, 2, 8);
    step();
    chk("pre_rst_fp", {7'd0, fp_a}, 8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk_idle("post_rst_idle");

    // Fresh sample after enable
    units = 4'd1; tens = 4'd6;
    en = 1'b1;
    step();
    chk_idle("restart_edge");
    phases(0, 7, 1, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
